// File: rtl/usb_hid_kbd_events_pkg.sv
// Shared types and constants for the USB HID boot-keyboard event path.
// Contents: usage constants, report/event structs, scan FSM state enum, and
// small key-slot search helpers used by the scanner.
package usb_hid_pkg;

  localparam logic [7:0] HID_MOD_USAGE_BASE = 8'hE0;
  localparam logic [7:0] HID_ERR_ROLLOVER   = 8'h01;
  localparam int         HID_KEY_SLOTS      = 6;

  typedef logic [HID_KEY_SLOTS-1:0][7:0] hid_keys_t;

  // Packed so that mod lands on report bits [7:0] and key[0] on bits [23:16].
  typedef struct packed {
    hid_keys_t  key;
    logic [7:0] rsvd;
    logic [7:0] mod;
  } hid_report_t;

  typedef struct packed {
    logic       pressed;
    logic [7:0] usage;
  } kbd_event_t;

  typedef enum logic [2:0] {IDLE, MOD, REL, PRS, COMMIT} scan_state_t;

  // True when any slot below 'limit' holds keycode 'k'.
  function automatic logic key_in(hid_keys_t keys, logic [7:0] k, logic [2:0] limit);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < HID_KEY_SLOTS; i++) begin
      if ((3'(i) < limit) && (keys[i] == k)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic has_rollover(hid_keys_t keys);
    return key_in(keys, HID_ERR_ROLLOVER, 3'(HID_KEY_SLOTS));
  endfunction

endpackage

// File: rtl/usb_hid_kbd_events_if.sv
// Bus between the HID host / CPU side and usb_hid_kbd_events.
// Report intake: usb_report_i, usb_report_valid_i.
// Event drain:   event_o, event_valid_o, event_ready_i, fifo_count_o.
// Status:        overflow_o, overrun_o (sticky), clear_i.
// slave = the event block, master = the host/CPU side.
interface usb_hid_kbd_events_if
  import usb_hid_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) ();

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [63:0]      usb_report_i;
  logic             usb_report_valid_i;
  kbd_event_t       event_o;
  logic             event_valid_o;
  logic             event_ready_i;
  logic [CNT_W-1:0] fifo_count_o;
  logic             overflow_o;
  logic             overrun_o;
  logic             clear_i;

  modport slave (
    input  usb_report_i, usb_report_valid_i, event_ready_i, clear_i,
    output event_o, event_valid_o, fifo_count_o, overflow_o, overrun_o
  );

  modport master (
    output usb_report_i, usb_report_valid_i, event_ready_i, clear_i,
    input  event_o, event_valid_o, fifo_count_o, overflow_o, overrun_o
  );

endinterface

// File: rtl/usb_hid_kbd_events_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports: clk, rst (async, active-high), push/wdata, pop, clear (sync flush),
//        rdata (head entry, valid when !empty), full, empty, count.
// A push while full is dropped unless a pop happens in the same cycle.
// A pop while empty is ignored. clear beats any push or pop in its cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/usb_hid_kbd_events.sv
// usb_hid_kbd_events: turns 8-byte boot-protocol keyboard reports into a
// stream of make/break events.
// Ports: clk, reset_i (async, active-high), bus (usb_hid_kbd_events_if.slave):
//   report intake, FWFT event output with valid/ready, occupancy, sticky
//   overflow/overrun flags and a synchronous clear.
// A report lands in a one-deep pending slot, then a fixed-length scan
// (IDLE, 8 x MOD, 6 x REL, 6 x PRS, COMMIT) diffs it against the last one.
module usb_hid_kbd_events
  import usb_hid_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned REPORT_BYTES = 8
) (
  input logic                  clk,
  input logic                  reset_i,
  usb_hid_kbd_events_if.slave  bus
);

  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned KeySlots = REPORT_BYTES - 2;

  scan_state_t state_q, state_d;
  logic [2:0]  idx_q, idx_d;

  hid_report_t new_rpt;
  logic [7:0]  pend_mod_q, cur_mod_q, prev_mod_q;
  hid_keys_t   pend_key_q, cur_key_q, prev_key_q;
  logic        pend_valid_q;
  logic        accept, take;
  logic        unused_rsvd;

  logic        push;
  kbd_event_t  push_evt;
  logic        pop, fifo_full, fifo_empty, drop;
  logic [8:0]  fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic        overflow_q, overrun_q;

  assign new_rpt     = hid_report_t'(bus.usb_report_i);
  assign unused_rsvd = ^new_rpt.rsvd;

  // ErrorRollOver reports carry no key state; drop them before they touch anything.
  assign accept = bus.usb_report_valid_i & ~has_rollover(new_rpt.key);
  assign take   = (state_q == IDLE) & pend_valid_q;

  // Pending slot: a report arriving as IDLE consumes the old one is not an overrun.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      pend_valid_q <= 1'b0;
      pend_mod_q   <= '0;
      pend_key_q   <= '0;
    end else begin
      if (accept) begin
        pend_mod_q <= new_rpt.mod;
        pend_key_q <= new_rpt.key;
      end
      pend_valid_q <= (pend_valid_q & ~take) | accept;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      cur_mod_q  <= '0;
      cur_key_q  <= '0;
      prev_mod_q <= '0;
      prev_key_q <= '0;
    end else begin
      if (take) begin
        cur_mod_q <= pend_mod_q;
        cur_key_q <= pend_key_q;
      end
      if (state_q == COMMIT) begin
        prev_mod_q <= cur_mod_q;
        prev_key_q <= cur_key_q;
      end
    end
  end

  // Scan FSM: state register.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Scan FSM: next state. Step counts are fixed, so latency never depends on content.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          state_d = MOD;
          idx_d   = '0;
        end
      end
      MOD: begin
        if (idx_q == 3'd7) begin
          state_d = REL;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      REL: begin
        if (idx_q == 3'(KeySlots - 1)) begin
          state_d = PRS;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      PRS: begin
        if (idx_q == 3'(KeySlots - 1)) begin
          state_d = COMMIT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan FSM: outputs. The "earlier slot" checks suppress duplicate keycodes.
  always_comb begin
    push     = 1'b0;
    push_evt = '0;
    unique case (state_q)
      MOD: begin
        if (cur_mod_q[idx_q] != prev_mod_q[idx_q]) begin
          push     = 1'b1;
          push_evt = '{pressed: cur_mod_q[idx_q], usage: HID_MOD_USAGE_BASE + {5'd0, idx_q}};
        end
      end
      REL: begin
        if ((prev_key_q[idx_q] != 8'h00)
            && !key_in(cur_key_q, prev_key_q[idx_q], 3'(KeySlots))
            && !key_in(prev_key_q, prev_key_q[idx_q], idx_q)) begin
          push     = 1'b1;
          push_evt = '{pressed: 1'b0, usage: prev_key_q[idx_q]};
        end
      end
      PRS: begin
        if ((cur_key_q[idx_q] != 8'h00)
            && !key_in(prev_key_q, cur_key_q[idx_q], 3'(KeySlots))
            && !key_in(cur_key_q, cur_key_q[idx_q], idx_q)) begin
          push     = 1'b1;
          push_evt = '{pressed: 1'b1, usage: cur_key_q[idx_q]};
        end
      end
      default: ;
    endcase
  end

  assign pop  = bus.event_ready_i & ~fifo_empty;
  assign drop = push & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset_i),
    .push  (push),
    .wdata (push_evt),
    .pop   (pop),
    .clear (bus.clear_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (bus.clear_i) begin
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (accept && pend_valid_q && !take) overrun_q <= 1'b1;
    end
  end

  assign bus.event_o       = kbd_event_t'(fifo_rdata);
  assign bus.event_valid_o = ~fifo_empty;
  assign bus.fifo_count_o  = fifo_count;
  assign bus.overflow_o    = overflow_q;
  assign bus.overrun_o     = overrun_q;

endmodule

// File: tb/tb_usb_hid_kbd_events.sv
// Directed bench for usb_hid_kbd_events with a 4-entry event FIFO.
module tb_usb_hid_kbd_events;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  usb_hid_kbd_events_if #(.FIFO_DEPTH(4)) bus ();

  usb_hid_kbd_events #(
    .FIFO_DEPTH   (4),
    .REPORT_BYTES (8)
  ) dut (
    .clk     (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] rpt, input logic clr);
    bus.usb_report_i       = rpt;
    bus.usb_report_valid_i = 1'b1;
    bus.clear_i            = clr;
    tick();
    bus.usb_report_valid_i = 1'b0;
    bus.clear_i            = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [8:0] exp);
    check({tag, "_valid"}, 16'(bus.event_valid_o), 16'd1);
    check(tag, 16'(bus.event_o), 16'(exp));
    bus.event_ready_i = 1'b1;
    tick();
    bus.event_ready_i = 1'b0;
  endtask

  initial begin
    rst                    = 1'b1;
    bus.usb_report_i       = '0;
    bus.usb_report_valid_i = 1'b0;
    bus.event_ready_i      = 1'b0;
    bus.clear_i            = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_valid",    16'(bus.event_valid_o), 16'd0);
    check("rst_event",    16'(bus.event_o),       16'd0);
    check("rst_count",    16'(bus.fifo_count_o),  16'd0);
    check("rst_overflow", 16'(bus.overflow_o),    16'd0);
    check("rst_overrun",  16'(bus.overrun_o),     16'd0);

    // Press 'A'; its press is pushed in the first PRS step, 16 cycles after intake.
    send(64'h0000_0000_0004_0000, 1'b0);
    repeat (15) tick();
    check("a_busy_count", 16'(bus.fifo_count_o), 16'd0);
    tick();
    check("a_press_count", 16'(bus.fifo_count_o), 16'd1);
    repeat (8) tick();
    pop_expect("a_press", 9'h104);
    check("a_drained", 16'(bus.fifo_count_o), 16'd0);

    send(64'h0, 1'b0);
    repeat (25) tick();
    check("a_rel_count", 16'(bus.fifo_count_o), 16'd1);
    pop_expect("a_rel", 9'h004);

    // Modifiers 0x00 -> 0x22 -> 0x20.
    send(64'h0000_0000_0000_0022, 1'b0);
    repeat (25) tick();
    check("mod_count", 16'(bus.fifo_count_o), 16'd2);
    pop_expect("mod_e1", 9'h1E1);
    pop_expect("mod_e5", 9'h1E5);
    send(64'h0000_0000_0000_0020, 1'b0);
    repeat (25) tick();
    check("mod2_count", 16'(bus.fifo_count_o), 16'd1);
    pop_expect("mod2_e1", 9'h0E1);

    // Keys {04,05}, mod 0x20 -> 0x00: release E5 then presses in slot order.
    send(64'h0000_0000_0504_0000, 1'b0);
    repeat (25) tick();
    check("set_count", 16'(bus.fifo_count_o), 16'd3);
    pop_expect("set_e5", 9'h0E5);
    pop_expect("set_04", 9'h104);
    pop_expect("set_05", 9'h105);

    // Shuffle with duplicate: {05,04,04,06} -> only 0x106.
    send(64'h0000_0604_0405_0000, 1'b0);
    repeat (25) tick();
    check("shuf_count", 16'(bus.fifo_count_o), 16'd1);
    pop_expect("shuf_06", 9'h106);

    // Back to {04}: releases 05 then 06.
    send(64'h0000_0000_0004_0000, 1'b0);
    repeat (25) tick();
    check("rel2_count", 16'(bus.fifo_count_o), 16'd2);
    pop_expect("rel2_05", 9'h005);
    pop_expect("rel2_06", 9'h006);

    // ErrorRollOver report is ignored; the next empty report releases 04.
    send(64'h0101_0101_0101_0000, 1'b0);
    repeat (25) tick();
    check("roll_count", 16'(bus.fifo_count_o), 16'd0);
    check("roll_valid", 16'(bus.event_valid_o), 16'd0);
    send(64'h0, 1'b0);
    repeat (25) tick();
    check("roll_rel_count", 16'(bus.fifo_count_o), 16'd1);
    pop_expect("roll_rel", 9'h004);

    // Six presses into a 4-deep FIFO: first four kept, overflow set.
    send(64'h0908_0706_0504_0000, 1'b0);
    repeat (25) tick();
    check("ovf_count",    16'(bus.fifo_count_o), 16'd4);
    check("ovf_flag",     16'(bus.overflow_o),   16'd1);
    check("ovf_overrun",  16'(bus.overrun_o),    16'd0);
    check("ovf_head",     16'(bus.event_o),      16'h104);
    pulse_clear();
    check("clr_count", 16'(bus.fifo_count_o),  16'd0);
    check("clr_flag",  16'(bus.overflow_o),    16'd0);
    check("clr_valid", 16'(bus.event_valid_o), 16'd0);

    // Clear coincident with a strobe: report still latched, prev kept -> release 09.
    send(64'h0008_0706_0504_0000, 1'b1);
    repeat (25) tick();
    check("clrstb_count", 16'(bus.fifo_count_o), 16'd1);
    pop_expect("clrstb_09", 9'h009);

    // Release all five: one too many for the FIFO.
    send(64'h0, 1'b0);
    repeat (25) tick();
    check("ovf2_flag", 16'(bus.overflow_o), 16'd1);
    pulse_clear();
    check("ovf2_clr", 16'(bus.overflow_o), 16'd0);

    // Overrun: strobes two cycles apart; the middle report never gets scanned.
    send(64'h0000_0000_0004_0000, 1'b0);
    tick();
    send(64'h0000_0000_0005_0000, 1'b0);
    tick();
    send(64'h0000_0000_0006_0000, 1'b0);
    check("ovr_flag", 16'(bus.overrun_o), 16'd1);
    repeat (50) tick();
    check("ovr_count", 16'(bus.fifo_count_o), 16'd3);
    pop_expect("ovr_104", 9'h104);
    pop_expect("ovr_004", 9'h004);
    pop_expect("ovr_106", 9'h106);
    pulse_clear();
    check("ovr_clr", 16'(bus.overrun_o), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_hid_kbd_events.md
Name: usb_hid_kbd_events

Overview:
Sits directly downstream of the USB HID host and upstream of the xgsoc keyboard register interface. It converts 8-byte boot-protocol keyboard reports into a stream of discrete key press/release events. Each new report is diffed against the last accepted report by a small scan FSM. Resulting events are buffered in a FIFO that the CPU drains via valid/ready.

Parameters:
FIFO_DEPTH, 16, event FIFO entries; power of 2, minimum 4.
REPORT_BYTES, 8, HID report length in bytes; fixed at 8 (boot protocol).

Ports:
clk  in  1  system clock; the report is already synchronised into this domain.
reset_i  in  1  asynchronous, active-high reset.
usb_report_i  in  64  report; byte0 = usb_report_i[7:0] = modifiers, byte1 reserved, bytes2..7 = keycode slots 0..5.
usb_report_valid_i  in  1  single-cycle strobe; report is stable in that cycle.
event_o  out  9  {pressed, usage[7:0]}; pressed = 1 for make, 0 for break.
event_valid_o  out  1  FIFO non-empty.
event_ready_i  in  1  pop when high and event_valid_o is high.
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupancy.
overflow_o  out  1  sticky: an event was dropped because the FIFO was full.
overrun_o  out  1  sticky: a pending report was overwritten before it was scanned.
clear_i  in  1  synchronous: clears overflow_o, overrun_o and the FIFO; does not clear prev report.

Behaviour:
- Reset: prev report = 0, pending empty, FSM IDLE, FIFO empty, event_o = 0, event_valid_o = 0, fifo_count_o = 0, both sticky flags = 0.
- Report intake: usb_report_valid_i latches the report into a one-deep pending register.
  - If pending is already full, the new report overwrites it and overrun_o is set.
  - A report whose any keycode slot equals 0x01 (ErrorRollOver) is discarded at intake: not latched, prev unchanged.
- FSM states and transitions:
  - IDLE: if pending is full, move it to cur, clear pending, go to MOD.
  - MOD: 8 cycles, bit i = 0..7. If cur.mod[i] != prev.mod[i], push {cur.mod[i], 8'hE0+i}.
  - REL: 6 cycles, slot j. If prev.key[j] != 0, and no cur slot equals it, and no earlier prev slot k<j equals it, push {0, prev.key[j]}.
  - PRS: 6 cycles, slot j. If cur.key[j] != 0, and no prev slot equals it, and no earlier cur slot k<j equals it, push {1, cur.key[j]}.
  - COMMIT: 1 cycle, prev <= cur, go to IDLE.
  - Fixed latency is 22 cycles from the valid strobe to IDLE, regardless of how many events are produced.
- Event order is always: modifier bits ascending, then releases by slot, then presses by slot.
- FIFO:
  - Push in the same cycle as the scan step.
  - If full, the event is dropped and overflow_o is set; the scan continues unstalled.
  - Simultaneous push and pop when full: the pop frees the entry first, so the push succeeds.
  - event_o is first-word-fall-through: it holds the head entry combinationally from the FIFO registers, and is held stable while valid && !ready.
  - Pointers wrap modulo FIFO_DEPTH; count saturates logically at FIFO_DEPTH.
- clear_i coincident with a push: clear wins and the pushed event is lost. clear_i in the same cycle as a valid strobe: the report is still latched.
- Async reset mid-scan aborts everything. The next report is diffed against an all-zero prev, so held keys re-emit presses.

Decomposition:
- Package usb_hid_pkg:
  - HID_MOD_USAGE_BASE = 8'hE0, HID_ERR_ROLLOVER = 8'h01.
  - typedef hid_report_t: struct of mod[7:0], rsvd[7:0], key[6][7:0].
  - typedef kbd_event_t: struct of pressed, usage[7:0].
  - enum scan_state_t {IDLE, MOD, REL, PRS, COMMIT}.
- Sub-module sync_fifo (WIDTH, DEPTH): FWFT, with push, pop, clear, full, empty, count. It is reusable by the PS/2 path.

Test Plan:
- Press/release 'A': report key0 = 0x04 -> one event 0x104. Then an all-zero report -> 0x004. fifo_count_o = 1 after each, 22-cycle busy window.
- Modifiers: mod 0x00 -> 0x22 -> events 0x1E1, 0x1E5 in that order. Then 0x22 -> 0x20 -> event 0x0E1 only.
- Slot shuffle/dup: prev {0x04,0x05}, new {0x05,0x04,0x04,0x06} -> single event 0x106, no releases.
- Rollover: prev {0x04}, report with 0x01 in all slots -> no events. The next all-zero report -> 0x004.
- FIFO_DEPTH = 4, ready held low, report pressing 6 distinct keys -> 4 events kept in slot order 0..3, overflow_o = 1. clear_i -> count 0, flag 0.
- Overrun: three valid strobes 2 cycles apart -> first scanned, second overwritten, third scanned against the first, overrun_o = 1.
